// File: rtl/i2c_slave_if.sv
// Bus pads and user-side handshake of the I2C target.
// The open-drain SDA pad is split into its resolved level (sda) and a pull-low enable (sda_oe).
interface i2c_slave_if;
    logic       scl;
    logic       sda;
    logic       sda_oe;
    logic       scl_oe;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic [7:0] tx_data;
    logic       tx_req;
    logic       addressed;
    logic       rw;
    logic       start_det;
    logic       stop_det;
    logic       nack_det;

    modport slave (
        input  scl, sda, rx_ready, tx_data,
        output sda_oe, scl_oe, rx_data, rx_valid, tx_req,
               addressed, rw, start_det, stop_det, nack_det
    );

    modport master (
        output scl, sda, rx_ready, tx_data,
        input  sda_oe, scl_oe, rx_data, rx_valid, tx_req,
               addressed, rw, start_det, stop_det, nack_det
    );
endinterface

// File: rtl/i2c_slave.sv
// Oversampling I2C target with 7-bit address, write delivery and read fetch handshakes.
// Optional clock stretching instead of NACK/immediate fetch: define I2C_SLAVE_STRETCH_EN.
module i2c_slave #(
    parameter logic [6:0] SLAVE_ADDR  = 7'h50,
    parameter int         SYNC_STAGES = 2
) (
    input logic        clk,
    input logic        rst_n,
    i2c_slave_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        WR_DATA,
        WR_ACK,
        RD_DATA,
        RD_ACK,
        STRETCH
    } state_t;

    logic [SYNC_STAGES-1:0] sclSync_q;
    logic [SYNC_STAGES-1:0] sdaSync_q;
    logic                   sclPrev_q;
    logic                   sdaPrev_q;

    state_t     state_q;
    logic [2:0] bitCnt_q;
    logic [6:0] shift_q;
    logic [6:0] txShift_q;
    logic       ackPhase_q;
    logic       ackNext_q;
    logic       sdaOe_q;
    logic [7:0] rxData_q;
    logic       rxValid_q;
    logic       txReq_q;
    logic       addressed_q;
    logic       rw_q;
    logic       startDet_q;
    logic       stopDet_q;
    logic       nackDet_q;
`ifdef I2C_SLAVE_STRETCH_EN
    logic       sclOe_q;
    logic       sclRelease_q;
    logic       readyPrev_q;
    logic [7:0] pendByte_q;
`endif

    logic       sclS;
    logic       sdaS;
    logic       sclRise;
    logic       sclFall;
    logic       startCond;
    logic       stopCond;
    logic [7:0] byteIn;

    assign sclS      = sclSync_q[SYNC_STAGES-1];
    assign sdaS      = sdaSync_q[SYNC_STAGES-1];
    assign sclRise   = sclS & ~sclPrev_q;
    assign sclFall   = ~sclS & sclPrev_q;
    assign startCond = sclS & sclPrev_q & sdaPrev_q & ~sdaS;
    assign stopCond  = sclS & sclPrev_q & ~sdaPrev_q & sdaS;
    assign byteIn    = {shift_q, sdaS};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclSync_q <= '1;
            sdaSync_q <= '1;
            sclPrev_q <= 1'b1;
            sdaPrev_q <= 1'b1;
        end else begin
            sclSync_q <= {sclSync_q[SYNC_STAGES-2:0], bus.scl};
            sdaSync_q <= {sdaSync_q[SYNC_STAGES-2:0], bus.sda};
            sclPrev_q <= sclS;
            sdaPrev_q <= sdaS;
        end
    end

    task automatic loadTx();
        txShift_q <= bus.tx_data[6:0];
        txReq_q   <= 1'b1;
        sdaOe_q   <= ~bus.tx_data[7];
        bitCnt_q  <= 3'd0;
        state_q   <= RD_DATA;
    endtask

    // With stretching, a fetch waits (SCL held low) until the user side was ready a cycle ago.
    task automatic beginRead();
`ifdef I2C_SLAVE_STRETCH_EN
        if (!readyPrev_q) begin
            sdaOe_q <= 1'b0;
            sclOe_q <= 1'b1;
            state_q <= STRETCH;
        end else begin
            loadTx();
        end
`else
        loadTx();
`endif
    endtask

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            bitCnt_q     <= 3'd0;
            shift_q      <= 7'd0;
            txShift_q    <= 7'd0;
            ackPhase_q   <= 1'b0;
            ackNext_q    <= 1'b0;
            sdaOe_q      <= 1'b0;
            rxData_q     <= 8'd0;
            rxValid_q    <= 1'b0;
            txReq_q      <= 1'b0;
            addressed_q  <= 1'b0;
            rw_q         <= 1'b0;
            startDet_q   <= 1'b0;
            stopDet_q    <= 1'b0;
            nackDet_q    <= 1'b0;
`ifdef I2C_SLAVE_STRETCH_EN
            sclOe_q      <= 1'b0;
            sclRelease_q <= 1'b0;
            readyPrev_q  <= 1'b0;
            pendByte_q   <= 8'd0;
`endif
        end else begin
            rxValid_q  <= 1'b0;
            txReq_q    <= 1'b0;
            startDet_q <= 1'b0;
            stopDet_q  <= 1'b0;
            nackDet_q  <= 1'b0;
`ifdef I2C_SLAVE_STRETCH_EN
            readyPrev_q <= bus.rx_ready;
            if (sclRelease_q) begin
                sclOe_q      <= 1'b0;
                sclRelease_q <= 1'b0;
            end
`endif
            if (startCond) begin
                state_q     <= ADDR;
                bitCnt_q    <= 3'd0;
                ackPhase_q  <= 1'b0;
                sdaOe_q     <= 1'b0;
                addressed_q <= 1'b0;
                startDet_q  <= 1'b1;
            end else if (stopCond) begin
                state_q     <= IDLE;
                bitCnt_q    <= 3'd0;
                ackPhase_q  <= 1'b0;
                sdaOe_q     <= 1'b0;
                addressed_q <= 1'b0;
                stopDet_q   <= 1'b1;
            end else begin
                case (state_q)
                    ADDR: begin
                        if (sclRise) begin
                            shift_q  <= byteIn[6:0];
                            bitCnt_q <= bitCnt_q + 3'd1;
                            if (bitCnt_q == 3'd7) begin
                                if (byteIn[7:1] == SLAVE_ADDR) begin
                                    rw_q       <= byteIn[0];
                                    ackPhase_q <= 1'b0;
                                    state_q    <= ADDR_ACK;
                                end else begin
                                    state_q <= IDLE;
                                end
                            end
                        end
                    end
                    // ackPhase_q separates the fall that starts the ACK bit from the one that ends it.
                    ADDR_ACK: begin
                        if (sclFall) begin
                            if (!ackPhase_q) begin
                                sdaOe_q    <= 1'b1;
                                ackPhase_q <= 1'b1;
                            end else begin
                                addressed_q <= 1'b1;
                                ackPhase_q  <= 1'b0;
                                if (rw_q) begin
                                    beginRead();
                                end else begin
                                    sdaOe_q <= 1'b0;
                                    state_q <= WR_DATA;
                                end
                            end
                        end
                    end
                    WR_DATA: begin
                        if (sclRise) begin
                            shift_q  <= byteIn[6:0];
                            bitCnt_q <= bitCnt_q + 3'd1;
                            if (bitCnt_q == 3'd7) begin
                                ackPhase_q <= 1'b0;
                                state_q    <= WR_ACK;
`ifdef I2C_SLAVE_STRETCH_EN
                                pendByte_q <= byteIn;
`endif
                                if (bus.rx_ready) begin
                                    rxData_q  <= byteIn;
                                    rxValid_q <= 1'b1;
                                    ackNext_q <= 1'b1;
                                end else begin
                                    ackNext_q <= 1'b0;
                                end
                            end
                        end
                    end
                    WR_ACK: begin
                        if (sclFall) begin
                            if (!ackPhase_q) begin
`ifdef I2C_SLAVE_STRETCH_EN
                                if (!ackNext_q) begin
                                    sclOe_q <= 1'b1;
                                    state_q <= STRETCH;
                                end else begin
                                    sdaOe_q    <= 1'b1;
                                    ackPhase_q <= 1'b1;
                                end
`else
                                sdaOe_q    <= ackNext_q;
                                ackPhase_q <= 1'b1;
`endif
                            end else begin
                                sdaOe_q    <= 1'b0;
                                bitCnt_q   <= 3'd0;
                                ackPhase_q <= 1'b0;
                                state_q    <= WR_DATA;
                            end
                        end
                    end
                    RD_DATA: begin
                        if (sclFall) begin
                            bitCnt_q <= bitCnt_q + 3'd1;
                            if (bitCnt_q == 3'd7) begin
                                sdaOe_q    <= 1'b0;
                                ackPhase_q <= 1'b0;
                                state_q    <= RD_ACK;
                            end else begin
                                sdaOe_q   <= ~txShift_q[6];
                                txShift_q <= {txShift_q[5:0], 1'b0};
                            end
                        end
                    end
                    RD_ACK: begin
                        if (sclRise && !ackPhase_q) begin
                            if (sdaS) begin
                                nackDet_q <= 1'b1;
                                state_q   <= IDLE;
                            end else begin
                                ackPhase_q <= 1'b1;
                            end
                        end else if (sclFall && ackPhase_q) begin
                            ackPhase_q <= 1'b0;
                            beginRead();
                        end
                    end
`ifdef I2C_SLAVE_STRETCH_EN
                    STRETCH: begin
                        if (bus.rx_ready) begin
                            sclRelease_q <= 1'b1;
                            if (rw_q) begin
                                loadTx();
                            end else begin
                                rxData_q   <= pendByte_q;
                                rxValid_q  <= 1'b1;
                                sdaOe_q    <= 1'b1;
                                ackPhase_q <= 1'b1;
                                state_q    <= WR_ACK;
                            end
                        end
                    end
`endif
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.sda_oe    = sdaOe_q;
    assign bus.rx_data   = rxData_q;
    assign bus.rx_valid  = rxValid_q;
    assign bus.tx_req    = txReq_q;
    assign bus.addressed = addressed_q;
    assign bus.rw        = rw_q;
    assign bus.start_det = startDet_q;
    assign bus.stop_det  = stopDet_q;
    assign bus.nack_det  = nackDet_q;
`ifdef I2C_SLAVE_STRETCH_EN
    assign bus.scl_oe    = sclOe_q;
`else
    assign bus.scl_oe    = 1'b0;
`endif

endmodule

// File: tb/tb_i2c_slave.sv
// Bit-banged I2C master driving a table of write vectors plus hand-written
// multi-byte, read, repeated-START and reset sequences against i2c_slave.
`timescale 1ns/1ps
module tb_i2c_slave;

    localparam int QUARTER      = 8;
    localparam int STRETCH_WAIT = 60;
    localparam int NVEC         = 5;

    typedef struct {
        logic [7:0] addrByte;
        logic [7:0] data;
        logic       ready;
        logic       expAddrAck;
        logic       expDataAck;
        int         expRxValid;
        logic [7:0] expRxData;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic mSclLow = 1'b0;
    logic mSdaLow = 1'b0;
    logic rxReadyReq = 1'b1;
    logic stretchRelease = 1'b0;
    logic [7:0] txList [4];
    int txBase = 0;

    int vectors = 0;
    int miscompares = 0;

    int rxValidCnt = 0;
    int txReqCnt = 0;
    int startCnt = 0;
    int stopCnt = 0;
    int nackCnt = 0;
    int coincCnt = 0;
    logic [7:0] rxLog [$];
    int stretchCnt = 0;
    int maxStretch = 0;

    vec_t vecs [NVEC];

    always #5 clk = ~clk;

    i2c_slave_if ifc ();

    // Wired-AND pads: master and target can only pull the lines low.
    assign ifc.scl      = ~(mSclLow | ifc.scl_oe);
    assign ifc.sda      = ~(mSdaLow | ifc.sda_oe);
    assign ifc.rx_ready = rxReadyReq | stretchRelease;
    assign ifc.tx_data  = txList[2'(txReqCnt - txBase)];

    i2c_slave #(
        .SLAVE_ADDR  (7'h50),
        .SYNC_STAGES (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc)
    );

    always @(negedge clk) begin
        if (ifc.rx_valid) begin
            rxValidCnt++;
            rxLog.push_back(ifc.rx_data);
        end
        if (ifc.tx_req)    txReqCnt++;
        if (ifc.start_det) startCnt++;
        if (ifc.stop_det)  stopCnt++;
        if (ifc.nack_det)  nackCnt++;
        if (ifc.rx_valid && ifc.stop_det) coincCnt++;
    end

    // Plays a slow user side: lets a held SCL sit for a while before offering rx_ready.
    always @(negedge clk) begin
        if (ifc.scl_oe) stretchCnt++;
        else            stretchCnt = 0;
        if (stretchCnt > maxStretch) maxStretch = stretchCnt;
        stretchRelease = (stretchCnt >= STRETCH_WAIT);
    end

    initial begin
        #2ms;
        $display("[TB] FAIL watchdog: time limit reached, got no finish, required finish");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic quarter();
        repeat (QUARTER) @(negedge clk);
    endtask

    task automatic sclHigh();
        int n;
        n = 0;
        mSclLow = 1'b0;
        while (ifc.scl !== 1'b1 && n < 4000) begin
            @(negedge clk);
            n++;
        end
        if (ifc.scl !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL scl_release: got scl=%b after %0d cycles, expected 1", ifc.scl, n);
        end
    endtask

    task automatic busBit(input logic b, output logic r);
        mSdaLow = ~b;
        quarter();
        sclHigh();
        quarter();
        r = ifc.sda;
        quarter();
        mSclLow = 1'b1;
        quarter();
    endtask

    task automatic i2cStart();
        mSdaLow = 1'b0;
        quarter();
        sclHigh();
        quarter();
        mSdaLow = 1'b1;
        quarter();
        mSclLow = 1'b1;
        quarter();
    endtask

    task automatic i2cStop();
        mSdaLow = 1'b1;
        quarter();
        sclHigh();
        quarter();
        mSdaLow = 1'b0;
        quarter();
        quarter();
    endtask

    task automatic writeByte(input logic [7:0] d, output logic ack);
        logic r;
        for (int i = 7; i >= 0; i--) busBit(d[i], r);
        busBit(1'b1, r);
        ack = ~r;
    endtask

    task automatic readByte(input logic masterAck, output logic [7:0] d);
        logic r;
        for (int i = 7; i >= 0; i--) begin
            busBit(1'b1, r);
            d[i] = r;
        end
        busBit(~masterAck, r);
    endtask

    task automatic applyStimulus(input vec_t v, output logic addrAck, output logic dataAck,
                                 output logic addrMid);
        rxReadyReq = v.ready;
        i2cStart();
        writeByte(v.addrByte, addrAck);
        writeByte(v.data, dataAck);
        addrMid = ifc.addressed;
        i2cStop();
        rxReadyReq = 1'b1;
    endtask

    initial begin
        logic aAck, dAck, aMid;
        logic [7:0] rd;
        int rxb, txb, stb, sp;

        vecs[0] = '{8'hA2, 8'h11, 1'b1, 1'b0, 1'b0, 0, 8'h3C};
`ifdef I2C_SLAVE_STRETCH_EN
        vecs[1] = '{8'hA0, 8'h77, 1'b0, 1'b1, 1'b1, 1, 8'h77};
`else
        vecs[1] = '{8'hA0, 8'h77, 1'b0, 1'b1, 1'b0, 0, 8'h3C};
`endif
        vecs[2] = '{8'hA0, 8'h00, 1'b1, 1'b1, 1'b1, 1, 8'h00};
        vecs[3] = '{8'h20, 8'hFF, 1'b1, 1'b0, 1'b0, 0, 8'h00};
        vecs[4] = '{8'hA0, 8'h81, 1'b1, 1'b1, 1'b1, 1, 8'h81};
        for (int i = 0; i < 4; i++) txList[i] = 8'h00;

        repeat (4) @(negedge clk);
        checkOutput("reset_sda_oe", ifc.sda_oe, 0);
        checkOutput("reset_outputs",
                    {ifc.scl_oe, ifc.rx_data, ifc.rx_valid, ifc.tx_req, ifc.addressed,
                     ifc.rw, ifc.start_det, ifc.stop_det, ifc.nack_det}, 0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        $display("[TB] two-byte write to 0x50");
        rxb = rxValidCnt; stb = stopCnt; sp = startCnt;
        i2cStart();
        writeByte(8'hA0, aAck);
        checkOutput("wr2_addr_ack", aAck, 1);
        writeByte(8'hA5, dAck);
        checkOutput("wr2_ack_a5", dAck, 1);
        writeByte(8'h3C, dAck);
        checkOutput("wr2_ack_3c", dAck, 1);
        checkOutput("wr2_addressed_before_stop", ifc.addressed, 1);
        i2cStop();
        checkOutput("wr2_rx_valid_count", rxValidCnt - rxb, 2);
        checkOutput("wr2_rx_byte0", rxLog[rxb], 8'hA5);
        checkOutput("wr2_rx_byte1", rxLog[rxb + 1], 8'h3C);
        checkOutput("wr2_stop_count", stopCnt - stb, 1);
        checkOutput("wr2_start_count", startCnt - sp, 1);
        checkOutput("wr2_addressed_after_stop", ifc.addressed, 0);

        for (int i = 0; i < NVEC; i++) begin
            $display("[TB] vector %0d: addr byte 0x%0h data 0x%0h ready %0b",
                     i, vecs[i].addrByte, vecs[i].data, vecs[i].ready);
            rxb = rxValidCnt; txb = txReqCnt;
            applyStimulus(vecs[i], aAck, dAck, aMid);
            checkOutput($sformatf("v%0d_addr_ack", i), aAck, vecs[i].expAddrAck);
            checkOutput($sformatf("v%0d_data_ack", i), dAck, vecs[i].expDataAck);
            checkOutput($sformatf("v%0d_addressed_mid", i), aMid, vecs[i].expAddrAck);
            checkOutput($sformatf("v%0d_rx_valid_count", i), rxValidCnt - rxb, vecs[i].expRxValid);
            checkOutput($sformatf("v%0d_rx_data", i), ifc.rx_data, vecs[i].expRxData);
            checkOutput($sformatf("v%0d_tx_req_count", i), txReqCnt - txb, 0);
            checkOutput($sformatf("v%0d_addressed_after_stop", i), ifc.addressed, 0);
        end

        $display("[TB] two-byte read from 0x50");
        txb = txReqCnt; sp = nackCnt;
        txBase = txReqCnt;
        txList[0] = 8'h96;
        txList[1] = 8'h0F;
        i2cStart();
        writeByte(8'hA1, aAck);
        checkOutput("rd_addr_ack", aAck, 1);
        readByte(1'b1, rd);
        checkOutput("rd_byte0", rd, 8'h96);
        readByte(1'b0, rd);
        checkOutput("rd_byte1", rd, 8'h0F);
        checkOutput("rd_sda_released", ifc.sda_oe, 0);
        checkOutput("rd_addressed_after_nack", ifc.addressed, 1);
        checkOutput("rd_rw", ifc.rw, 1);
        i2cStop();
        checkOutput("rd_tx_req_count", txReqCnt - txb, 2);
        checkOutput("rd_nack_count", nackCnt - sp, 1);
        checkOutput("rd_addressed_after_stop", ifc.addressed, 0);

        $display("[TB] write then repeated START read");
        rxb = rxValidCnt; txb = txReqCnt; sp = startCnt;
        txBase = txReqCnt;
        txList[0] = 8'h5A;
        i2cStart();
        writeByte(8'hA0, aAck);
        checkOutput("rs_wr_addr_ack", aAck, 1);
        checkOutput("rs_rw_write", ifc.rw, 0);
        writeByte(8'h12, dAck);
        checkOutput("rs_wr_data_ack", dAck, 1);
        i2cStart();
        writeByte(8'hA1, aAck);
        checkOutput("rs_rd_addr_ack", aAck, 1);
        checkOutput("rs_rw_read", ifc.rw, 1);
        readByte(1'b0, rd);
        checkOutput("rs_rd_byte", rd, 8'h5A);
        i2cStop();
        checkOutput("rs_start_count", startCnt - sp, 2);
        checkOutput("rs_rx_data", ifc.rx_data, 8'h12);
        checkOutput("rs_rx_valid_count", rxValidCnt - rxb, 1);
        checkOutput("rs_tx_req_count", txReqCnt - txb, 1);

        $display("[TB] reset during a read with SDA held low");
        txBase = txReqCnt;
        txList[0] = 8'h3F;
        i2cStart();
        writeByte(8'hA1, aAck);
        checkOutput("rst_addr_ack", aAck, 1);
        checkOutput("rst_sda_driven_before", ifc.sda_oe, 1);
        rst_n = 1'b0;
        #1;
        checkOutput("rst_sda_released_async", ifc.sda_oe, 0);
        checkOutput("rst_outputs_cleared",
                    {ifc.scl_oe, ifc.rx_data, ifc.rx_valid, ifc.tx_req, ifc.addressed,
                     ifc.rw, ifc.start_det, ifc.stop_det, ifc.nack_det}, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        rxb = rxValidCnt;
        i2cStart();
        writeByte(8'hA0, aAck);
        checkOutput("post_rst_addr_ack", aAck, 1);
        writeByte(8'hC3, dAck);
        checkOutput("post_rst_data_ack", dAck, 1);
        i2cStop();
        checkOutput("post_rst_rx_data", ifc.rx_data, 8'hC3);
        checkOutput("post_rst_rx_valid_count", rxValidCnt - rxb, 1);

        checkOutput("rx_valid_stop_coincide", coincCnt, 0);
`ifdef I2C_SLAVE_STRETCH_EN
        checkOutput("scl_stretch_held", maxStretch >= STRETCH_WAIT, 1);
`else
        checkOutput("scl_oe_never_set", maxStretch, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/i2c_slave.md
Name: i2c_slave

Overview:
- I2C target (responder) with a 7-bit address.
- Sits on the same SCL/SDA bus as the team's I2C master.
- Oversamples SCL/SDA on the system clock, detects START/STOP, matches the address, and ACKs.
- Delivers written bytes on a valid pulse and fetches read bytes from the user side with a request pulse.

Parameters:
- SLAVE_ADDR, 7'h50, bus address this target responds to.
- SYNC_STAGES, 2, synchronizer depth on SCL and SDA inputs (minimum 2).

Ports:
- clk  input  1  system clock; must be at least 16x SCL.
- rst_n  input  1  asynchronous active-low reset.
- scl  input  1  bus clock (external pull-up).
- sda  inout  1  bus data, open-drain: driven 0 or high-Z, never driven 1.
- scl_oe  output  1  when 1, SCL is pulled low for clock stretching (board ties it to an open-drain pad).
- rx_data  output  8  last byte written by the master.
- rx_valid  output  1  1-cycle pulse; rx_data is updated in that cycle.
- rx_ready  input  1  user can accept a byte; sampled at the 8th data bit.
- tx_data  input  8  byte to return on a read.
- tx_req  output  1  1-cycle pulse; tx_data is latched in that cycle.
- addressed  output  1  high from address ACK until STOP or repeated START.
- rw  output  1  R/W bit of the current transfer (1 = read).
- start_det  output  1  1-cycle pulse on START or repeated START.
- stop_det  output  1  1-cycle pulse on STOP.
- nack_det  output  1  1-cycle pulse when the master NACKs a read byte.

Behaviour:
Reset:
- All outputs 0; sda released (high-Z); state IDLE; bit counter 0.
- Synchronizer flops reset to 1.
- Reset mid-transfer releases SDA immediately (asynchronous).

Edge detection (on synchronized signals):
- SCL rise/fall: compare current vs previous sample; latency SYNC_STAGES+1 cycles.
- START: SDA falls while SCL high.
- STOP: SDA rises while SCL high.
- START/STOP override every state.
  - START -> ADDR, bit counter cleared, start_det pulse.
  - STOP -> IDLE, SDA released, stop_det pulse.

Sampling and driving:
- Input bits sampled on SCL rise, MSB first.
- SDA output changes only on SCL fall.

State machine:
- IDLE: wait for START.
- ADDR: shift 8 bits on SCL rises. After the 8th bit:
  - Match ({addr7} == SLAVE_ADDR): latch rw; on next SCL fall drive SDA low -> ADDR_ACK.
  - Mismatch: -> IDLE (ignore the bus until the next START).
- ADDR_ACK: on the SCL fall ending the ACK bit, set addressed=1.
  - rw=0: release SDA -> WR_DATA.
  - rw=1: latch tx_data and pulse tx_req in the same cycle; drive bit7 -> RD_DATA.
- WR_DATA: shift 8 bits. At the 8th SCL rise:
  - rx_ready=1: rx_data <= shifted byte, rx_valid pulse, ACK (drive low) on next SCL fall.
  - rx_ready=0: rx_valid stays 0, rx_data unchanged, SDA stays released (NACK).
  - Either way -> WR_ACK.
- WR_ACK: on SCL fall release SDA -> WR_DATA, bit counter 0.
- RD_DATA: on each SCL fall drive the next bit. Drive 0 as low; release for 1.
  - After the 8th bit's SCL fall, release SDA -> RD_ACK.
- RD_ACK: sample SDA on SCL rise.
  - 0 (ACK): on SCL fall latch tx_data, pulse tx_req, drive bit7 -> RD_DATA.
  - 1 (NACK): pulse nack_det; SDA stays released; -> IDLE. addressed stays 1 until STOP or START.

Edge cases:
- Bit counter wraps 7->0 only through the ACK states.
- A START or STOP at any bit position aborts the byte; no rx_valid is issued for a partial byte.
- rx_valid and stop_det never coincide; STOP is only legal with SCL high after an ACK phase.

Optional Feature:
- Macro: I2C_SLAVE_STRETCH_EN.
- Defined:
  - Read path: if tx_req would fire but the 1-cycle-earlier sample of input rx_ready (reused as "tx_ready" when rw=1) is 0, assert scl_oe on that SCL fall and hold it. When rx_ready rises, latch tx_data, pulse tx_req, drive bit7, and release scl_oe one cycle later.
  - Write path: when rx_ready=0 at the 8th bit, stretch (hold scl_oe) instead of NACKing. When rx_ready rises, pulse rx_valid and ACK.
- Undefined: scl_oe is constant 0, and the NACK/immediate-latch behaviour above applies.

Test Plan:
- Write addr 0x50, data 0xA5, 0x3C, then STOP, rx_ready=1 -> address ACK; rx_valid twice with rx_data 0xA5 then 0x3C; both ACKed; stop_det once; addressed falls after STOP.
- Write to addr 0x51 -> no ACK (SDA high at 9th clock); addressed, rx_valid and tx_req all stay 0.
- Read from 0x50 with tx_data 0x96 then 0x0F; master ACKs the first byte and NACKs the second -> bus returns 0x96, 0x0F; tx_req pulses twice; nack_det once; SDA released.
- Write 0x50 with 0x12; repeated START; read one byte -> start_det twice; rw goes 0->1; rx_data=0x12; tx_req once.
- rx_ready=0 during write byte 0x77 -> NACK on the 9th clock and no rx_valid. With I2C_SLAVE_STRETCH_EN: SCL held low until rx_ready=1, then rx_valid with 0x77 and ACK.
- Assert rst_n low mid read (SDA driven low) -> SDA released within the reset; all outputs 0; next START from the master is handled normally.
